entrada_acondicionador: RTL and testbench
=========================================

// Module: entrada_acondicionador
// PURPOSE
//  Front end for all user inputs: synchronises, debounces and edge-detects the raw buttons and sensors.
//  Drives BancoRegistro's btn_*, sns_* and test inputs with clean single-cycle events and stable levels.
//  Adds auto-repeat on comer_inc/curar_dec while held, and a long-press toggle that produces the test level.
// PARAMETERS
//  DEB_CYCLES    1_000_000  consecutive stable cycles needed to accept a level change (20 ms @ 50 MHz)
//  LONG_CYCLES   150_000_000  hold time of btn_test_raw that toggles test (3 s)
//  REP_DELAY     25_000_000  hold time before auto-repeat starts on inc/dec (0.5 s)
//  REP_PERIOD    10_000_000  auto-repeat pulse spacing (0.2 s)
//  BTN_ACT_LOW   1          1: raw buttons read 0 when pressed; sensors are always active-high
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous reset, active-high
//  btn_comer_inc_raw,btn_curar_dec_raw,btn_next_raw,btn_back_raw,btn_test_raw  in 1 each  raw pushbuttons
//  sns_prox_raw,sns_temp_raw,sns_luz_raw  in 1 each  raw sensor levels
//  btn_comer_inc  out  1  one-cycle press pulse, plus auto-repeat pulses
//  btn_curar_dec  out  1  one-cycle press pulse, plus auto-repeat pulses
//  btn_next       out  1  one-cycle press pulse
//  btn_back       out  1  one-cycle press pulse
//  test           out  1  test-mode level, toggled by a long press
//  sns_prox,sns_temp,sns_luz  out 1 each  debounced sensor levels
//  sns_change     out  3  one-cycle pulse per sensor on any debounced change, {luz,temp,prox}
// BEHAVIOUR
//  Reset (async, asserted):
//   - every output is 0, every counter is 0, every debounced state is "released"/0.
//   - a button held through reset release produces exactly one press pulse after normal latency.
//  Sync: each raw input passes a 2-FF synchroniser. Button polarity is normalised (pressed=1) after sync.
//  Debounce, per channel:
//   - cnt increments on each cycle where the synced value s != the stable value st.
//   - cnt clears on any cycle where s == st.
//   - when s != st and cnt == DEB_CYCLES-1: st <= s and cnt <= 0.
//   - a glitch shorter than DEB_CYCLES cycles never changes st.
//  Edge outputs are registered: pulse = st & ~st_d, high for exactly 1 cycle.
//   - latency from raw change (set up before edge 0) to pulse high is DEB_CYCLES+3 edges.
//   - sensor levels follow st with DEB_CYCLES+2 edges latency; sns_change pulses 1 cycle after a level change.
//  Auto-repeat, inc/dec channels:
//   - hold counter runs while st==1 and clears on release.
//   - first repeat pulse when hold reaches REP_DELAY; then one pulse every REP_PERIOD cycles.
//   - counters saturate, no wrap. Releasing stops repeats immediately, even mid-period.
//  Long press, test channel:
//   - FSM IDLE -> HOLD when st rises; HOLD -> IDLE on release before LONG_CYCLES, no effect.
//   - HOLD -> LATCHED on reaching LONG_CYCLES: test <= ~test.
//   - LATCHED -> IDLE only on release, so one hold toggles test exactly once.
//  Conflicts, checked on the same cycle:
//   - btn_next and btn_back both pending: both suppressed.
//   - inc and dec both pending: both suppressed; their repeat counters keep running.
//  Sensors never auto-repeat and are not subject to conflict suppression.
// TESTING (bench uses DEB_CYCLES=4, LONG_CYCLES=40, REP_DELAY=20, REP_PERIOD=8, BTN_ACT_LOW=1)
//  btn_next_raw 1->0 held 30 cycles -> btn_next high exactly 1 cycle, 7 edges after the change; no further pulses.
//  btn_back_raw low for 3 cycles then high (glitch) -> btn_back stays 0.
//  btn_comer_inc_raw held low 60 cycles -> pulses at t=7, 27, 35, 43, 51, 59; released -> no more pulses.
//  btn_test_raw held 50 cycles -> test 0->1 once, at t~=46; second hold of 10 cycles -> test stays 1.
//  next and back pressed on the same cycle -> neither pulse appears; sns_luz_raw 0->1 -> sns_luz=1 at t=6, sns_change[2] 1-cycle pulse at t=7.
//  rst asserted mid-debounce and mid-hold -> all outputs 0 immediately; button still held after release -> one pulse at DEB_CYCLES+3.

Source files
------------

// File: rtl/entrada_acondicionador.sv
// Input conditioning front end: synchronises, debounces and edge-detects the raw
// buttons and sensors, with auto-repeat on inc/dec and a long-press test toggle.
module entrada_acondicionador #(
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned LONG_CYCLES = 150_000_000,
    parameter int unsigned REP_DELAY   = 25_000_000,
    parameter int unsigned REP_PERIOD  = 10_000_000,
    parameter bit          BTN_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_comer_inc_raw,
    input  logic       btn_curar_dec_raw,
    input  logic       btn_next_raw,
    input  logic       btn_back_raw,
    input  logic       btn_test_raw,
    input  logic       sns_prox_raw,
    input  logic       sns_temp_raw,
    input  logic       sns_luz_raw,
    output logic       btn_comer_inc,
    output logic       btn_curar_dec,
    output logic       btn_next,
    output logic       btn_back,
    output logic       test,
    output logic       sns_prox,
    output logic       sns_temp,
    output logic       sns_luz,
    output logic [2:0] sns_change
);

    localparam int NCH     = 8;
    localparam int CH_INC  = 0;
    localparam int CH_DEC  = 1;
    localparam int CH_NEXT = 2;
    localparam int CH_BACK = 3;
    localparam int CH_TEST = 4;
    localparam int CH_PROX = 5;
    localparam int CH_LUZ  = 7;

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam int HOLD_W = $clog2(REP_DELAY + 1);
    localparam int PER_W  = (REP_PERIOD > 1) ? $clog2(REP_PERIOD) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(REP_DELAY);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(REP_PERIOD - 1);

    // Raw level of each channel when nothing is pressed or sensed.
    localparam logic [NCH-1:0] RAW_IDLE = {3'b000, {5{BTN_ACT_LOW}}};

    typedef enum logic [1:0] {
        LP_IDLE,
        LP_HOLD,
        LP_LATCHED
    } lp_state_t;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync_a;
    logic [NCH-1:0] sync_b;
    logic [NCH-1:0] s;
    logic [NCH-1:0] st;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] lvl_d;
    logic [NCH-1:0] rise;
    logic [DEB_W-1:0] deb_cnt [NCH];

    logic [HOLD_W-1:0] hold_cnt [2];
    logic [PER_W-1:0]  per_cnt  [2];
    logic [1:0]        rep_hit;

    logic pend_inc;
    logic pend_dec;
    logic pend_next;
    logic pend_back;

    lp_state_t         lp_state;
    logic [LONG_W-1:0] long_cnt;

    assign raw = {sns_luz_raw, sns_temp_raw, sns_prox_raw, btn_test_raw,
                  btn_back_raw, btn_next_raw, btn_curar_dec_raw, btn_comer_inc_raw};

    // Synchronisers reset to the idle raw level so reset release never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= RAW_IDLE;
            sync_b <= RAW_IDLE;
        end else begin
            // NOTE: non-blocking so both stages sample on the same edge; blocking would collapse the pair into one flop.
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    assign s = sync_b ^ RAW_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the per-channel counters are plain flops, not a RAM, so they take the reset like any other state.
            for (int i = 0; i < NCH; i++) begin
                deb_cnt[i] <= '0;
            end
            st <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (s[i] == st[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    st[i]      <= s[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl   <= '0;
            lvl_d <= '0;
        end else begin
            lvl   <= st;
            lvl_d <= lvl;
        end
    end

    assign rise = lvl & ~lvl_d;

    // Repeat fires when the hold count has saturated at REP_DELAY and the period counter wraps.
    always_comb begin
        // NOTE: default first so every path assigns rep_hit and no latch is inferred.
        rep_hit = '0;
        for (int i = 0; i < 2; i++) begin
            rep_hit[i] = lvl[i] && (hold_cnt[i] == HOLD_MAX) && (per_cnt[i] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                hold_cnt[i] <= '0;
                per_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!lvl[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != HOLD_MAX) begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end

                if (lvl[i] && (hold_cnt[i] == HOLD_MAX)) begin
                    per_cnt[i] <= (per_cnt[i] == PER_LAST) ? '0 : per_cnt[i] + 1'b1;
                end else begin
                    per_cnt[i] <= '0;
                end
            end
        end
    end

    assign pend_inc  = rise[CH_INC] | rep_hit[CH_INC];
    assign pend_dec  = rise[CH_DEC] | rep_hit[CH_DEC];
    assign pend_next = rise[CH_NEXT];
    assign pend_back = rise[CH_BACK];

    // Opposing requests on the same cycle cancel each other; repeat counters keep running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_comer_inc <= 1'b0;
            btn_curar_dec <= 1'b0;
            btn_next      <= 1'b0;
            btn_back      <= 1'b0;
            sns_change    <= '0;
        end else begin
            btn_comer_inc <= pend_inc & ~pend_dec;
            btn_curar_dec <= pend_dec & ~pend_inc;
            btn_next      <= pend_next & ~pend_back;
            btn_back      <= pend_back & ~pend_next;
            sns_change    <= lvl[CH_LUZ:CH_PROX] ^ lvl_d[CH_LUZ:CH_PROX];
        end
    end

    assign sns_prox = lvl[CH_PROX];
    assign sns_temp = lvl[CH_PROX+1];
    assign sns_luz  = lvl[CH_LUZ];

    // LATCHED waits for release so one long hold toggles test exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lp_state <= LP_IDLE;
            long_cnt <= '0;
            test     <= 1'b0;
        end else begin
            case (lp_state)
                LP_IDLE: begin
                    if (lvl[CH_TEST]) begin
                        lp_state <= LP_HOLD;
                        long_cnt <= LONG_W'(1);
                    end
                end
                LP_HOLD: begin
                    if (!lvl[CH_TEST]) begin
                        lp_state <= LP_IDLE;
                    end else if (long_cnt == LONG_LAST) begin
                        lp_state <= LP_LATCHED;
                        test     <= ~test;
                    end else begin
                        long_cnt <= long_cnt + 1'b1;
                    end
                end
                LP_LATCHED: begin
                    if (!lvl[CH_TEST]) begin
                        lp_state <= LP_IDLE;
                    end
                end
                default: begin
                    lp_state <= LP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_entrada_acondicionador.sv
// Bench for entrada_acondicionador: an age-based behavioural model checked every
// cycle, plus directed scenarios with hand-computed event times.
module tb_entrada_acondicionador;

    localparam int DEB_CYCLES  = 4;
    localparam int LONG_CYCLES = 40;
    localparam int REP_DELAY   = 20;
    localparam int REP_PERIOD  = 8;

    logic clk;
    logic rst;
    logic btn_comer_inc_raw, btn_curar_dec_raw, btn_next_raw, btn_back_raw, btn_test_raw;
    logic sns_prox_raw, sns_temp_raw, sns_luz_raw;
    logic btn_comer_inc, btn_curar_dec, btn_next, btn_back, test;
    logic sns_prox, sns_temp, sns_luz;
    logic [2:0] sns_change;

    entrada_acondicionador #(
        .DEB_CYCLES (DEB_CYCLES),
        .LONG_CYCLES(LONG_CYCLES),
        .REP_DELAY  (REP_DELAY),
        .REP_PERIOD (REP_PERIOD),
        .BTN_ACT_LOW(1'b1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_comer_inc_raw(btn_comer_inc_raw),
        .btn_curar_dec_raw(btn_curar_dec_raw),
        .btn_next_raw     (btn_next_raw),
        .btn_back_raw     (btn_back_raw),
        .btn_test_raw     (btn_test_raw),
        .sns_prox_raw     (sns_prox_raw),
        .sns_temp_raw     (sns_temp_raw),
        .sns_luz_raw      (sns_luz_raw),
        .btn_comer_inc    (btn_comer_inc),
        .btn_curar_dec    (btn_curar_dec),
        .btn_next         (btn_next),
        .btn_back         (btn_back),
        .test             (test),
        .sns_prox         (sns_prox),
        .sns_temp         (sns_temp),
        .sns_luz          (sns_luz),
        .sns_change       (sns_change)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: pressed/asserted is 1 after normalisation; ages count consecutive samples at level 1.
    logic [7:0] m_f1, m_s, m_st, m_lvl, m_lvlp;
    int         m_run [8];
    int         m_age [8];
    logic       m_inc, m_dec, m_next, m_back, m_test;
    logic [2:0] m_chg;
    logic       p_inc, p_dec, p_next, p_back;

    function automatic logic [7:0] raw_norm();
        return {sns_luz_raw, sns_temp_raw, sns_prox_raw, ~btn_test_raw,
                ~btn_back_raw, ~btn_next_raw, ~btn_curar_dec_raw, ~btn_comer_inc_raw};
    endfunction

    // A held inc/dec fires on its first level cycle, then at REP_DELAY and every REP_PERIOD after.
    function automatic logic rep_due(input int age);
        return (age == 1) || (age > REP_DELAY && ((age - 1 - REP_DELAY) % REP_PERIOD) == 0);
    endfunction

    task automatic model_reset();
        m_f1 = '0; m_s = '0; m_st = '0; m_lvl = '0; m_lvlp = '0;
        for (int i = 0; i < 8; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
        m_inc = 0; m_dec = 0; m_next = 0; m_back = 0; m_test = 0; m_chg = '0;
    endtask

    task automatic model_step();
        p_inc  = m_lvl[0] && rep_due(m_age[0]);
        p_dec  = m_lvl[1] && rep_due(m_age[1]);
        p_next = m_lvl[2] && (m_age[2] == 1);
        p_back = m_lvl[3] && (m_age[3] == 1);
        m_inc  = p_inc && !p_dec;
        m_dec  = p_dec && !p_inc;
        m_next = p_next && !p_back;
        m_back = p_back && !p_next;
        m_chg  = m_lvl[7:5] ^ m_lvlp[7:5];
        if (m_lvl[4] && m_age[4] == LONG_CYCLES) m_test = !m_test;
        m_lvlp = m_lvl;
        m_lvl  = m_st;
        for (int i = 0; i < 8; i++) begin
            if (m_s[i] != m_st[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB_CYCLES) begin
                    m_st[i]  = m_s[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s  = m_f1;
        m_f1 = raw_norm();
        for (int i = 0; i < 8; i++) m_age[i] = m_lvl[i] ? m_age[i] + 1 : 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic [10:0] dut_vec, mdl_vec;
    assign dut_vec = {btn_comer_inc, btn_curar_dec, btn_next, btn_back, test,
                      sns_prox, sns_temp, sns_luz, sns_change};
    assign mdl_vec = {m_inc, m_dec, m_next, m_back, m_test, m_lvl[5], m_lvl[6], m_lvl[7], m_chg};

    int   q_inc[$], q_dec[$], q_next[$], q_back[$], q_test[$], q_luz[$], q_chg2[$];
    logic test_prev = 1'b0;
    logic luz_prev  = 1'b0;

    // Per-cycle model comparison and event logging, half a cycle after each active edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("cycle_outputs", 32'(dut_vec), 32'(mdl_vec));
            if (btn_comer_inc) q_inc.push_back(cyc);
            if (btn_curar_dec) q_dec.push_back(cyc);
            if (btn_next) q_next.push_back(cyc);
            if (btn_back) q_back.push_back(cyc);
            if (test != test_prev) q_test.push_back(cyc);
            if (sns_luz && !luz_prev) q_luz.push_back(cyc);
            if (sns_change[2]) q_chg2.push_back(cyc);
        end
        test_prev = test;
        luz_prev  = sns_luz;
    end

    task automatic clear_logs();
        q_inc.delete(); q_dec.delete(); q_next.delete(); q_back.delete();
        q_test.delete(); q_luz.delete(); q_chg2.delete();
    endtask

    int base;
    int exp_rep [6] = '{7, 27, 35, 43, 51, 59};

    initial begin
        rst = 1'b1;
        btn_comer_inc_raw = 1'b1; btn_curar_dec_raw = 1'b1; btn_next_raw = 1'b1;
        btn_back_raw = 1'b1; btn_test_raw = 1'b1;
        sns_prox_raw = 1'b0; sns_temp_raw = 1'b0; sns_luz_raw = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset_outputs", 32'(dut_vec), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single press on next: one pulse, 7 edges after the change.
        clear_logs();
        btn_next_raw = 1'b0;
        base = cyc + 1;
        repeat (30) @(negedge clk);
        btn_next_raw = 1'b1;
        repeat (15) @(negedge clk);
        check("next_pulse_count", q_next.size(), 1);
        check("next_pulse_time", (q_next.size() > 0) ? q_next[0] - base : -1, 7);

        // Three-cycle glitch on back is shorter than the debounce window.
        clear_logs();
        btn_back_raw = 1'b0;
        repeat (3) @(negedge clk);
        btn_back_raw = 1'b1;
        repeat (20) @(negedge clk);
        check("back_glitch_count", q_back.size(), 0);

        // Held inc: press pulse then auto-repeat; release ends repeats.
        clear_logs();
        btn_comer_inc_raw = 1'b0;
        base = cyc + 1;
        repeat (60) @(negedge clk);
        btn_comer_inc_raw = 1'b1;
        repeat (25) @(negedge clk);
        check("inc_pulse_count", q_inc.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < q_inc.size()) check("inc_pulse_time", q_inc[k] - base, exp_rep[k]);
        end
        check("inc_no_dec", q_dec.size(), 0);

        // Long hold toggles test once; a short hold leaves it.
        clear_logs();
        btn_test_raw = 1'b0;
        base = cyc + 1;
        repeat (50) @(negedge clk);
        btn_test_raw = 1'b1;
        repeat (20) @(negedge clk);
        check("test_after_long", 32'(test), 32'd1);
        check("test_toggle_time", (q_test.size() > 0) ? q_test[0] - base : -1, 46);
        btn_test_raw = 1'b0;
        repeat (10) @(negedge clk);
        btn_test_raw = 1'b1;
        repeat (20) @(negedge clk);
        check("test_toggle_count", q_test.size(), 1);
        check("test_after_short", 32'(test), 32'd1);

        // next+back together cancel; luz rises alongside without suppression.
        clear_logs();
        btn_next_raw = 1'b0;
        btn_back_raw = 1'b0;
        sns_luz_raw  = 1'b1;
        base = cyc + 1;
        repeat (20) @(negedge clk);
        btn_next_raw = 1'b1;
        btn_back_raw = 1'b1;
        repeat (15) @(negedge clk);
        check("conflict_next", q_next.size(), 0);
        check("conflict_back", q_back.size(), 0);
        check("luz_level_time", (q_luz.size() > 0) ? q_luz[0] - base : -1, 6);
        check("luz_change_count", q_chg2.size(), 1);
        check("luz_change_time", (q_chg2.size() > 0) ? q_chg2[0] - base : -1, 7);

        // inc+dec together cancel, including their first repeat.
        clear_logs();
        btn_comer_inc_raw = 1'b0;
        btn_curar_dec_raw = 1'b0;
        repeat (30) @(negedge clk);
        btn_comer_inc_raw = 1'b1;
        btn_curar_dec_raw = 1'b1;
        repeat (15) @(negedge clk);
        check("conflict_inc", q_inc.size(), 0);
        check("conflict_dec", q_dec.size(), 0);

        // Reset in the middle of a test hold and an inc debounce.
        sns_prox_raw = 1'b1;
        repeat (10) @(negedge clk);
        check("prox_level", 32'(sns_prox), 32'd1);
        btn_test_raw = 1'b0;
        repeat (22) @(negedge clk);
        btn_comer_inc_raw = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 check("reset_immediate", 32'(dut_vec), 32'd0);
        @(negedge clk);
        btn_test_raw = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        base = cyc + 1;
        repeat (15) @(negedge clk);
        check("post_reset_inc_count", q_inc.size(), 1);
        check("post_reset_inc_time", (q_inc.size() > 0) ? q_inc[0] - base : -1, 7);
        check("post_reset_test", 32'(test), 32'd0);
        btn_comer_inc_raw = 1'b1;
        repeat (15) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
